escalonador_display_erros: RTL and testbench

Controller that shares the machine's single multiplexed 7-segment display among four latched error sources (sensor SR, water level, temperature, cup). It generates the 2-bit digit-scan counter that drives the per-message segment decoders, drives the active-low digit anodes, and rotates round-robin through pending errors until the operator acknowledges each one. It sits between the sensor/error logic and the message decoder bank plus the display pins.

---
 rtl/escalonador_display_erros.sv | 142 ++++++++++++++
 tb/tb_escalonador_display_erros.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/escalonador_display_erros.sv
// Shares one multiplexed 7-segment display among four latched error sources.
// Rotates round-robin through pending errors. Each message is held for a fixed
// number of full digit scans, or until the operator acknowledges it.
module escalonador_display_erros #(
  parameter int REFRESH_DIV = 50000,
  parameter int HOLD_SCANS  = 250
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] erro,
  input  logic       limpar,
  output logic       saida1Contador,
  output logic       saida2Contador,
  output logic [3:0] anodo,
  output logic [1:0] mensagem,
  output logic       ativo,
  output logic [3:0] pendentes
);

  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int SW = (HOLD_SCANS > 1) ? $clog2(HOLD_SCANS) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(HOLD_SCANS - 1);

  localparam logic [1:0] OCIOSO = 2'd0;
  localparam logic [1:0] TROCA  = 2'd1;
  localparam logic [1:0] EXIBE  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [3:0]    pend_q, pend_d;
  logic [1:0]    msg_q, msg_d;
  logic [1:0]    next_msg;
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    digit_q, digit_d;
  logic [SW-1:0] scan_q, scan_d;
  logic [3:0]    anodo_q, anodo_d;
  logic          ativo_q, ativo_d;

  // Pending latch per source: a raw error sets the bit (and wins over an
  // acknowledge); an acknowledge only clears the bit of the message on screen.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_pend
      assign pend_d[gi] = erro[gi] |
                          (pend_q[gi] & ~(limpar & (state_q == EXIBE) & (msg_q == 2'(gi))));
    end
  endgenerate

  // Round-robin search starting just after the current message, ending on it.
  always_comb begin
    logic       found;
    logic [1:0] idx;
    next_msg = msg_q;
    found    = 1'b0;
    idx      = 2'd0;
    for (int j = 1; j <= 4; j++) begin
      idx = msg_q + 2'(j);
      if (!found && pend_q[idx]) begin
        next_msg = idx;
        found    = 1'b1;
      end
    end
  end

  // Next-state, scan counters and registered display outputs.
  always_comb begin
    state_d = state_q;
    msg_d   = msg_q;
    presc_d = '0;
    digit_d = '0;
    scan_d  = '0;
    case (state_q)
      OCIOSO: begin
        if (|pend_q) state_d = TROCA;
      end
      TROCA: begin
        if (|pend_q) begin
          state_d = EXIBE;
          msg_d   = next_msg;
        end else begin
          state_d = OCIOSO;
        end
      end
      EXIBE: begin
        if (!pend_q[msg_q]) begin
          // Message acknowledged: leave immediately; counters restart at zero.
          state_d = TROCA;
        end else begin
          presc_d = presc_q + 1'b1;
          digit_d = digit_q;
          scan_d  = scan_q;
          if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            digit_d = digit_q + 2'd1;
            if (digit_q == 2'd3) begin
              scan_d = scan_q + 1'b1;
              if (scan_q == SCAN_LAST) begin
                scan_d  = '0;
                state_d = TROCA;
              end
            end
          end
        end
      end
      default: state_d = OCIOSO;
    endcase
    ativo_d = (state_d == EXIBE);
    anodo_d = (state_d == EXIBE) ? ~(4'b0001 << digit_d) : 4'b1111;
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= OCIOSO;
      pend_q  <= '0;
      msg_q   <= 2'b11;
      presc_q <= '0;
      digit_q <= '0;
      scan_q  <= '0;
      anodo_q <= 4'b1111;
      ativo_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      msg_q   <= msg_d;
      presc_q <= presc_d;
      digit_q <= digit_d;
      scan_q  <= scan_d;
      anodo_q <= anodo_d;
      ativo_q <= ativo_d;
    end
  end

  assign saida1Contador = digit_q[1];
  assign saida2Contador = digit_q[0];
  assign anodo          = anodo_q;
  assign mensagem       = msg_q;
  assign ativo          = ativo_q;
  assign pendentes      = pend_q;

endmodule

// File: tb/tb_escalonador_display_erros.sv
// Bench for escalonador_display_erros: a cycle model driven by elapsed display
// time, checked on every falling edge, plus hand-computed directed checks.
module tb_escalonador_display_erros;

  localparam int RD   = 4;
  localparam int HS   = 2;
  localparam int HOLD = 4 * RD * HS;

  localparam int IDLE  = 0;
  localparam int BLANK = 1;
  localparam int SHOW  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] erro = 4'b0000;
  logic       limpar = 1'b0;
  logic       s1, s2;
  logic [3:0] anodo;
  logic [1:0] mensagem;
  logic       ativo;
  logic [3:0] pendentes;

  int n_chk  = 0;
  int n_fail = 0;

  // Model state
  int         m_mode = IDLE;
  logic [1:0] m_msg  = 2'b11;
  logic [3:0] m_pend = 4'b0000;
  int         m_t    = 0;

  escalonador_display_erros #(.REFRESH_DIV(RD), .HOLD_SCANS(HS)) dut (
    .clock(clk),
    .reset(rst),
    .erro(erro),
    .limpar(limpar),
    .saida1Contador(s1),
    .saida2Contador(s2),
    .anodo(anodo),
    .mensagem(mensagem),
    .ativo(ativo),
    .pendentes(pendentes)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] search(input logic [1:0] m, input logic [3:0] p);
    int r;
    r = m;
    for (int j = 4; j >= 1; j--)
      if (p[(m + j) % 4]) r = (m + j) % 4;
    return 2'(r);
  endfunction

  // Model: display time m_t counts cycles since the current message appeared.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode <= IDLE;
      m_msg  <= 2'b11;
      m_pend <= 4'b0000;
      m_t    <= 0;
    end else begin
      m_pend <= erro | (m_pend & ~((limpar && m_mode == SHOW) ? (4'b0001 << m_msg) : 4'b0000));
      case (m_mode)
        IDLE:  if (m_pend != 0) m_mode <= BLANK;
        BLANK: begin
          if (m_pend == 0) m_mode <= IDLE;
          else begin
            m_mode <= SHOW;
            m_msg  <= search(m_msg, m_pend);
            m_t    <= 0;
          end
        end
        default: begin
          if (!m_pend[m_msg] || m_t == HOLD - 1) m_mode <= BLANK;
          else m_t <= m_t + 1;
        end
      endcase
    end
  end

  // Compare every cycle against the model.
  always @(negedge clk) begin
    logic [1:0] dig;
    logic [3:0] ea;
    dig = (m_mode == SHOW) ? 2'((m_t / RD) % 4) : 2'd0;
    ea  = (m_mode == SHOW) ? ~(4'b0001 << dig) : 4'b1111;
    chk("cyc_anodo", 32'(anodo), 32'(ea));
    chk("cyc_ativo", 32'(ativo), 32'(m_mode == SHOW));
    chk("cyc_pend", 32'(pendentes), 32'(m_pend));
    chk("cyc_msg", 32'(mensagem), 32'(m_msg));
    chk("cyc_digit", 32'({s1, s2}), 32'(dig));
    $display("cyc t=%0t erro=%b limpar=%b anodo=%b ativo=%b msg=%0d pend=%b", $time, erro, limpar, anodo, ativo, mensagem, pendentes);
  end

  task automatic wait_mode(input int m);
    int n;
    n = 0;
    while (m_mode != m && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (m_mode != m) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_mode: got mode %0d expected %0d within 200 cycles", m_mode, m);
    end
  endtask

  task automatic ack;
    limpar = 1'b1;
    @(negedge clk);
    limpar = 1'b0;
  endtask

  initial begin
    // Reset then idle
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    chk("idle_anodo", 32'(anodo), 32'h0000_000F);
    chk("idle_ativo", 32'(ativo), 32'h0);
    chk("idle_pend", 32'(pendentes), 32'h0);
    chk("idle_digit", 32'({s1, s2}), 32'h0);

    // Single one-cycle error on source 0
    @(negedge clk); erro = 4'b0001;
    @(negedge clk); erro = 4'b0000;
    chk("lat_pend_k", 32'(pendentes), 32'h1);
    chk("lat_ativo_k", 32'(ativo), 32'h0);
    @(negedge clk);
    chk("lat_ativo_k1", 32'(ativo), 32'h0);
    @(negedge clk);
    chk("lat_ativo_k2", 32'(ativo), 32'h1);
    chk("lat_anodo_k2", 32'(anodo), 32'hE);
    chk("lat_msg_k2", 32'(mensagem), 32'h0);
    repeat (4) @(negedge clk);
    chk("step_d1", 32'(anodo), 32'hD);
    repeat (4) @(negedge clk);
    chk("step_d2", 32'(anodo), 32'hB);
    repeat (4) @(negedge clk);
    chk("step_d3", 32'(anodo), 32'h7);
    repeat (20) @(negedge clk);
    chk("hold_blank", 32'(anodo), 32'hF);
    chk("hold_blank_ativo", 32'(ativo), 32'h0);
    @(negedge clk);
    chk("hold_reenter", 32'(anodo), 32'hE);
    chk("hold_msg", 32'(mensagem), 32'h0);
    ack();
    chk("ack_pend", 32'(pendentes), 32'h0);
    @(negedge clk);
    chk("ack_troca", 32'(ativo), 32'h0);
    @(negedge clk);
    chk("ack_idle_msg", 32'(mensagem), 32'h0);

    // Round-robin between sources 1 and 3
    erro = 4'b1010;
    wait_mode(SHOW);
    chk("rr_first", 32'(mensagem), 32'h1);
    wait_mode(BLANK); wait_mode(SHOW);
    chk("rr_second", 32'(mensagem), 32'h3);
    wait_mode(BLANK); wait_mode(SHOW);
    chk("rr_third", 32'(mensagem), 32'h1);
    erro = 4'b0000;
    ack();
    wait_mode(BLANK); wait_mode(SHOW);
    chk("rr_after_ack", 32'(mensagem), 32'h3);
    ack();
    wait_mode(IDLE);

    // Acknowledge mid-digit with sources 1 and 2 pending
    @(negedge clk); erro = 4'b0110;
    @(negedge clk); erro = 4'b0000;
    wait_mode(SHOW);
    chk("mid_msg", 32'(mensagem), 32'h1);
    repeat (2) @(negedge clk);
    ack();
    chk("mid_pend", 32'(pendentes), 32'h4);
    @(negedge clk);
    chk("mid_troca", 32'(anodo), 32'hF);
    @(negedge clk);
    chk("mid_next_msg", 32'(mensagem), 32'h2);
    chk("mid_next_digit", 32'({s1, s2}), 32'h0);
    chk("mid_next_anodo", 32'(anodo), 32'hE);
    ack();
    wait_mode(IDLE);

    // Acknowledge and re-set of the same source in one cycle
    @(negedge clk); erro = 4'b0001;
    @(negedge clk); erro = 4'b0000;
    wait_mode(SHOW);
    chk("race_msg", 32'(mensagem), 32'h0);
    limpar = 1'b1; erro = 4'b0001;
    @(negedge clk);
    limpar = 1'b0; erro = 4'b0000;
    chk("race_pend", 32'(pendentes), 32'h1);
    chk("race_ativo", 32'(ativo), 32'h1);
    wait_mode(BLANK); wait_mode(SHOW);
    chk("race_reenter", 32'(mensagem), 32'h0);
    ack();
    wait_mode(IDLE);

    // Asynchronous reset during digit 2
    @(negedge clk); erro = 4'b0100;
    @(negedge clk); erro = 4'b0000;
    wait_mode(SHOW);
    repeat (8) @(negedge clk);
    chk("rst_pre_anodo", 32'(anodo), 32'hB);
    #2 rst = 1'b1;
    #1;
    chk("rst_anodo", 32'(anodo), 32'hF);
    chk("rst_ativo", 32'(ativo), 32'h0);
    chk("rst_pend", 32'(pendentes), 32'h0);
    chk("rst_msg", 32'(mensagem), 32'h3);
    chk("rst_digit", 32'({s1, s2}), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("post_rst_ativo", 32'(ativo), 32'h0);
    chk("post_rst_anodo", 32'(anodo), 32'hF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
